// File: rtl/pc.sv
// Program counter state register: loads the next PC on every rising edge.
// Stalls are made upstream by feeding pc_o back into nxt_pc_i.
module pc #(
    parameter int unsigned             WIDTH     = 32,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] nxt_pc_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;

    // Stored verbatim: no masking, increment or X sanitising.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= nxt_pc_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: reset, load, hold, async reset, stream, X.
// Expected values are hand-computed constants.
module tb_pc;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] nxt_pc_i;
    logic [31:0] pc_o;

    int total;
    int bad;

    pc #(
        .WIDTH    (32),
        .RESET_VAL(32'h0000_0000)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .nxt_pc_i(nxt_pc_i),
        .pc_o    (pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
            $display("%0t PASS %s clk=%b rst_ni=%b nxt=%h pc=%h exp=%h",
                     $time, tag, clk_i, rst_ni, nxt_pc_i, got, exp);
        else begin
            bad++;
            $display("%0t FAIL %s clk=%b rst_ni=%b nxt=%h got=%h exp=%h",
                     $time, tag, clk_i, rst_ni, nxt_pc_i, got, exp);
        end
    endtask

    // Drive on the falling edge, then land 1 unit after the rising edge.
    task automatic step(input logic [31:0] v);
        @(negedge clk_i);
        nxt_pc_i = v;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_ni   = 1'b0;
        nxt_pc_i = 32'hFFFF_FFFF;
        #1;
        chk("rst_async_t0", pc_o, 32'h0000_0000);
        @(posedge clk_i);
        #1;
        chk("rst_edge", pc_o, 32'h0000_0000);
        step(32'h5555_5555);
        chk("rst_hold_edge", pc_o, 32'h0000_0000);

        @(negedge clk_i);
        rst_ni   = 1'b1;
        nxt_pc_i = 32'h0000_00F7;
        #1;
        chk("release_no_edge", pc_o, 32'h0000_0000);
        @(posedge clk_i);
        #1;
        chk("load_f7", pc_o, 32'h0000_00F7);

        @(negedge clk_i);
        nxt_pc_i = 32'h1234_5678;
        #1;
        chk("hold_mid", pc_o, 32'h0000_00F7);
        @(posedge clk_i);
        #1;
        chk("load_12345678", pc_o, 32'h1234_5678);

        step(32'hDEAD_BEEF);
        chk("load_deadbeef", pc_o, 32'hDEAD_BEEF);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_mid", pc_o, 32'h0000_0000);
        step(32'hAAAA_AAAA);
        chk("rst_low_edge1", pc_o, 32'h0000_0000);
        step(32'h8000_0001);
        chk("rst_low_edge2", pc_o, 32'h0000_0000);

        @(negedge clk_i);
        rst_ni = 1'b1;
        step(32'h0000_0000);
        chk("stream_0", pc_o, 32'h0000_0000);
        step(32'h0000_0004);
        chk("stream_4", pc_o, 32'h0000_0004);
        step(32'h0000_0008);
        chk("stream_8", pc_o, 32'h0000_0008);
        step(32'hFFFF_FFFC);
        chk("stream_fffffffc", pc_o, 32'hFFFF_FFFC);

        step(32'hFFFF_FFFC);
        chk("stall_feedback", pc_o, 32'hFFFF_FFFC);
        step(32'hFFFF_FFFF);
        chk("all_ones", pc_o, 32'hFFFF_FFFF);
        step(32'h0000_0003);
        chk("unaligned", pc_o, 32'h0000_0003);
        step(32'hxxxx_xxxx);
        chk("x_propagate", pc_o, 32'hxxxx_xxxx);
        step(32'h7FFF_FFFF);
        chk("after_x", pc_o, 32'h7FFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
